// File: rtl/fb_arbiter_if.sv
// Signal bundle between the display/draw side and the framebuffer arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface fb_arbiter_if;
    logic        i_pix_stb;
    logic        i_active;
    logic        i_animate;
    logic [9:0]  i_x;
    logic [8:0]  i_y;
    logic        i_wr_valid;
    logic [15:0] i_wr_addr;
    logic [7:0]  i_wr_data;
    logic        o_wr_ready;
    logic        i_clr_req;
    logic [7:0]  i_clr_color;
    logic        i_swap_req;
    logic        o_busy;
    logic        o_clr_done;
    logic        o_front;
    logic [16:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic [7:0]  o_pix_data;

    modport master (
        output i_pix_stb, i_active, i_animate, i_x, i_y,
        output i_wr_valid, i_wr_addr, i_wr_data, i_clr_req, i_clr_color, i_swap_req,
        output i_mem_rdata,
        input  o_wr_ready, o_busy, o_clr_done, o_front,
        input  o_mem_addr, o_mem_we, o_mem_wdata, o_pix_data
    );

    modport slave (
        input  i_pix_stb, i_active, i_animate, i_x, i_y,
        input  i_wr_valid, i_wr_addr, i_wr_data, i_clr_req, i_clr_color, i_swap_req,
        input  i_mem_rdata,
        output o_wr_ready, o_busy, o_clr_done, o_front,
        output o_mem_addr, o_mem_we, o_mem_wdata, o_pix_data
    );
endinterface

// File: rtl/fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads own pixel-strobe slots, draw writes,
// bulk clears and frame-synchronous bank swaps share the remaining RAM cycles.
module fb_arbiter #(
    parameter int unsigned FB_W    = 320,
    parameter int unsigned FB_H    = 180,
    parameter int unsigned FB_SIZE = FB_W * FB_H
) (
    input logic          i_clk,
    input logic          i_rst_n,
    fb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StClear, StSwapWait} state_e;

    state_e      state_q;
    logic        front_q;
    logic        swap_pend_q;
    logic [15:0] clr_cnt_q;
    logic [7:0]  clr_color_q;
    logic        clr_done_q;
    logic        rd_pend_q;
    logic [7:0]  pix_data_q;

    logic        rd_slot;
    logic        wr_slot;
    logic [15:0] y_ext;
    logic [15:0] y_term;
    logic [15:0] rd_offset;
    logic        wr_ready;
    logic        wr_hs;
    logic        clr_wr;

    assign y_ext = {7'b0, bus.i_y};

    if (FB_W == 320) begin : g_shift
        assign y_term = (y_ext << 8) + (y_ext << 6);
    end else begin : g_mul
        assign y_term = 16'(y_ext * 16'(FB_W));
    end

    assign rd_offset = y_term + {6'b0, bus.i_x};
    assign rd_slot   = bus.i_pix_stb & bus.i_active;
    assign wr_slot   = ~rd_slot;

    // Outputs are forced quiet while reset is held so nothing reaches the RAM.
    assign wr_ready = i_rst_n && (state_q == StIdle) && wr_slot && !swap_pend_q;
    assign wr_hs    = wr_ready && bus.i_wr_valid;
    assign clr_wr   = i_rst_n && (state_q == StClear) && wr_slot;

    always_comb begin
        bus.o_mem_addr  = {front_q, rd_offset};
        bus.o_mem_we    = 1'b0;
        bus.o_mem_wdata = 8'h00;
        if (wr_hs) begin
            bus.o_mem_addr  = {~front_q, bus.i_wr_addr};
            bus.o_mem_we    = (bus.i_wr_addr < 16'(FB_SIZE));
            bus.o_mem_wdata = bus.i_wr_data;
        end else if (clr_wr) begin
            bus.o_mem_addr  = {~front_q, clr_cnt_q};
            bus.o_mem_we    = 1'b1;
            bus.o_mem_wdata = clr_color_q;
        end
    end

    assign bus.o_wr_ready = wr_ready;
    assign bus.o_busy     = i_rst_n && ((state_q != StIdle) || swap_pend_q);
    assign bus.o_clr_done = clr_done_q;
    assign bus.o_front    = front_q;
    assign bus.o_pix_data = pix_data_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
            clr_cnt_q   <= 16'h0000;
            clr_color_q <= 8'h00;
            clr_done_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            pix_data_q  <= 8'h00;
        end else begin
            clr_done_q <= 1'b0;
            rd_pend_q  <= rd_slot;
            // RAM data arrives the cycle after the read slot; blanking strobes override it.
            if (rd_pend_q) pix_data_q <= bus.i_mem_rdata;
            if (bus.i_pix_stb && !bus.i_active) pix_data_q <= 8'h00;
            if (bus.i_swap_req) swap_pend_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (bus.i_clr_req) begin
                        state_q     <= StClear;
                        clr_cnt_q   <= 16'h0000;
                        clr_color_q <= bus.i_clr_color;
                    end else if (swap_pend_q) begin
                        state_q <= StSwapWait;
                    end
                end
                StClear: begin
                    if (wr_slot) begin
                        if (clr_cnt_q == 16'(FB_SIZE - 1)) begin
                            clr_done_q <= 1'b1;
                            clr_cnt_q  <= 16'h0000;
                            state_q    <= (swap_pend_q || bus.i_swap_req) ? StSwapWait : StIdle;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 16'h0001;
                        end
                    end
                end
                StSwapWait: begin
                    // Clearing the pending flag here wins over a coincident request: one swap.
                    if (bus.i_animate && bus.i_pix_stb) begin
                        front_q     <= ~front_q;
                        swap_pend_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency framebuffer RAM.
module tb_fb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if bus ();

    fb_arbiter u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    logic [7:0]  mem [131072];
    logic [7:0]  rdata_q;
    logic        pl_en;
    logic [16:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        rdata_q <= mem[bus.o_mem_addr];
    end
    assign bus.i_mem_rdata = rdata_q;

    int   checks = 0;
    int   errors = 0;
    logic in_clear = 1'b0;
    int   disp_wr = 0;
    int   oob_wr = 0;
    int   clr_cnt = 0;
    int   clr_bad = 0;
    int   done_cnt = 0;

    always @(posedge clk) begin
        if (rst_n && bus.o_mem_we) begin
            if (bus.o_mem_addr[16] == bus.o_front) disp_wr <= disp_wr + 1;
            if (bus.o_mem_addr[15:0] >= 16'd57600) oob_wr <= oob_wr + 1;
            if (in_clear) begin
                if (bus.o_mem_addr != {1'b1, clr_cnt[15:0]} || bus.o_mem_wdata != 8'h07)
                    clr_bad <= clr_bad + 1;
                clr_cnt <= clr_cnt + 1;
            end
        end
        if (bus.o_clr_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  front_bad;
        logic done;

        bus.i_pix_stb = 0; bus.i_active = 0; bus.i_animate = 0;
        bus.i_x = '0; bus.i_y = '0;
        bus.i_wr_valid = 1; bus.i_wr_addr = 16'd3; bus.i_wr_data = 8'h11;
        bus.i_clr_req = 0; bus.i_clr_color = 8'h00; bus.i_swap_req = 0;
        pl_en = 1; pl_addr = 17'd321; pl_data = 8'h5A;

        // Reset state, with a pending write request that must be refused.
        @(negedge clk);
        pl_addr = 17'd65857; pl_data = 8'h33;
        @(negedge clk);
        pl_en = 0;
        #1;
        check("rst_wr_ready", bus.o_wr_ready, 0);
        check("rst_we", bus.o_mem_we, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_front", bus.o_front, 0);
        check("rst_pix", bus.o_pix_data, 0);
        check("rst_clr_done", bus.o_clr_done, 0);
        @(negedge clk);
        rst_n = 1; bus.i_wr_valid = 0;

        // Read path: x=1,y=1 -> bank0 offset 321, data visible two edges later.
        @(negedge clk);
        bus.i_pix_stb = 1; bus.i_active = 1; bus.i_x = 10'd1; bus.i_y = 9'd1;
        #1;
        check("rd_addr", bus.o_mem_addr, 32'h00141);
        check("rd_we", bus.o_mem_we, 0);
        @(negedge clk);
        bus.i_pix_stb = 0;
        #1;
        check("rd_pix_early", bus.o_pix_data, 0);
        @(posedge clk); #1;
        check("rd_pix", bus.o_pix_data, 32'h5A);

        // Write arbitration along an active line.
        bus.i_y = 9'd2; bus.i_wr_valid = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.i_pix_stb = (k % 2 == 0); bus.i_x = 10'(k);
            bus.i_wr_addr = 16'(100 + k); bus.i_wr_data = 8'(8'hA0 + k);
            #1;
            if (k % 2 == 0) begin
                check("arb_rd_ready", bus.o_wr_ready, 0);
                check("arb_rd_we", bus.o_mem_we, 0);
            end else begin
                check("arb_wr_ready", bus.o_wr_ready, 1);
                check("arb_wr_addr", bus.o_mem_addr, 32'h10000 + 32'(100 + k));
                check("arb_wr_data", bus.o_mem_wdata, 32'hA0 + 32'(k));
            end
        end
        @(negedge clk);
        bus.i_pix_stb = 0; bus.i_wr_valid = 0;
        #1;
        check("arb_mem103", mem[65536 + 103], 32'hA3);

        // Address boundary: last legal offset written, first illegal one dropped.
        @(negedge clk);
        bus.i_wr_valid = 1; bus.i_wr_addr = 16'd57599; bus.i_wr_data = 8'hEE;
        #1;
        check("wr_last_we", bus.o_mem_we, 1);
        @(negedge clk);
        bus.i_wr_addr = 16'd57600; bus.i_wr_data = 8'hFF;
        #1;
        check("wr_oob_ready", bus.o_wr_ready, 1);
        check("wr_oob_we", bus.o_mem_we, 0);
        @(negedge clk);
        bus.i_wr_valid = 0;

        // Blanking strobe zeroes the pixel output.
        bus.i_pix_stb = 1; bus.i_active = 1; bus.i_x = 10'd1; bus.i_y = 9'd1;
        @(negedge clk);
        bus.i_pix_stb = 0;
        @(negedge clk);
        check("blank_pre", bus.o_pix_data, 32'h5A);
        bus.i_pix_stb = 1; bus.i_active = 0;
        @(posedge clk); #1;
        check("blank_zero", bus.o_pix_data, 0);

        // Mid-frame swap: writes stall until the animate strobe.
        @(negedge clk);
        bus.i_pix_stb = 0; bus.i_active = 1; bus.i_swap_req = 1;
        @(negedge clk);
        bus.i_swap_req = 0; bus.i_wr_valid = 1; bus.i_wr_addr = 16'd5; bus.i_wr_data = 8'h55;
        #1;
        check("swap_busy", bus.o_busy, 1);
        check("swap_stall", bus.o_wr_ready, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.i_pix_stb = (k % 2 == 0);
        end
        #1;
        check("swap_front_hold", bus.o_front, 0);
        @(negedge clk);
        bus.i_pix_stb = 1; bus.i_active = 1; bus.i_animate = 1; bus.i_x = 10'd1; bus.i_y = 9'd1;
        #1;
        check("swap_rd_addr", bus.o_mem_addr, 32'h00141);
        @(posedge clk); #1;
        check("swap_front", bus.o_front, 1);
        check("swap_busy_clr", bus.o_busy, 0);
        @(negedge clk);
        bus.i_pix_stb = 0; bus.i_animate = 0;
        #1;
        check("swap_wr_ready", bus.o_wr_ready, 1);
        check("swap_wr_addr", bus.o_mem_addr, 32'h00005);
        @(posedge clk); #1;
        check("swap_inflight_pix", bus.o_pix_data, 32'h5A);

        // Repeated swap requests while pending give a single toggle.
        @(negedge clk);
        bus.i_wr_valid = 0; bus.i_swap_req = 1;
        @(negedge clk);
        bus.i_swap_req = 0;
        @(negedge clk);
        bus.i_swap_req = 1;
        @(negedge clk);
        bus.i_swap_req = 0; bus.i_pix_stb = 1; bus.i_active = 0; bus.i_animate = 1;
        @(posedge clk); #1;
        check("dbl_swap_front", bus.o_front, 0);
        @(posedge clk); #1;
        check("dbl_swap_no_second", bus.o_front, 0);
        check("dbl_swap_busy", bus.o_busy, 0);

        // Clear and swap requested together: clear completes, then the swap.
        @(negedge clk);
        bus.i_pix_stb = 0; bus.i_animate = 0;
        bus.i_clr_req = 1; bus.i_swap_req = 1; bus.i_clr_color = 8'h07;
        in_clear = 1;
        @(negedge clk);
        bus.i_clr_req = 0; bus.i_swap_req = 0;
        bus.i_wr_valid = 1; bus.i_wr_addr = 16'd9;
        bus.i_pix_stb = 1; bus.i_animate = 1;
        #1;
        check("clr_ready", bus.o_wr_ready, 0);
        check("clr_busy", bus.o_busy, 1);
        front_bad = 0;
        done = 0;
        for (int i = 0; i < 60000 && !done; i++) begin
            @(posedge clk); #1;
            if (bus.o_front !== 1'b0) front_bad++;
            if (bus.o_clr_done === 1'b1) done = 1;
        end
        in_clear = 0;
        check("clr_done_seen", done, 1);
        check("clr_front_held", front_bad, 0);
        check("clr_busy_after", bus.o_busy, 1);
        check("clr_write_count", clr_cnt, 57600);
        check("clr_bad_writes", clr_bad, 0);
        check("clr_mem_first", mem[65536], 32'h07);
        check("clr_mem_last", mem[65536 + 57599], 32'h07);
        @(posedge clk); #1;
        check("clr_done_pulse", bus.o_clr_done, 0);
        check("clr_then_swap", bus.o_front, 1);
        check("clr_swap_idle", bus.o_busy, 0);
        check("clr_done_count", done_cnt, 1);

        // Reset mid-clear abandons the clear and the front selection.
        @(negedge clk);
        bus.i_pix_stb = 0; bus.i_animate = 0; bus.i_wr_valid = 0;
        bus.i_clr_req = 1; bus.i_clr_color = 8'h11;
        @(negedge clk);
        bus.i_clr_req = 0;
        repeat (50) @(negedge clk);
        #1;
        check("midclr_busy", bus.o_busy, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check("rst_mid_busy", bus.o_busy, 0);
        check("rst_mid_front", bus.o_front, 0);
        check("rst_mid_we", bus.o_mem_we, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_abandon_we", bus.o_mem_we, 0);
        check("rst_abandon_busy", bus.o_busy, 0);
        @(negedge clk);
        bus.i_wr_valid = 1; bus.i_wr_addr = 16'd7; bus.i_wr_data = 8'h77;
        #1;
        check("rst_idle_ready", bus.o_wr_ready, 1);
        check("rst_idle_addr", bus.o_mem_addr, 32'h10007);
        @(negedge clk);
        bus.i_wr_valid = 0;
        #1;
        check("no_display_writes", disp_wr, 0);
        check("no_oob_writes", oob_wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
